trace_stream_scheduler: RTL

- Sits after trace_filter. Takes each retired instruction (pc, instr) together with the filter's drop_instr verdict, and decides whether to capture it according to the configured mode.
- Captured records are buffered in a FIFO and handed to the downstream trace consumer over a valid/ready stream.
- On FIFO overflow, lost records are counted and one marker record is inserted once space returns.
- Raises halt_cpu when the FIFO is almost full.

---
 rtl/trace_stream_scheduler_if.sv | 28 ++
 rtl/trace_stream_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/trace_stream_scheduler_if.sv
// trace_stream_scheduler_if
//   Valid/ready record stream from the trace scheduler to the trace consumer.
//   m_valid     : head record present
//   m_ready     : consumer accepts the head record this cycle
//   m_data      : {pc, instr} or overflow-marker payload
//   m_is_marker : head record is an overflow marker
interface trace_stream_scheduler_if #(
   parameter int unsigned DATA_WIDTH = 96
);
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_is_marker;

   modport master (
      output m_valid,
      output m_data,
      output m_is_marker,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_is_marker,
      output m_ready
   );
endinterface

// File: rtl/trace_stream_scheduler.sv
// trace_stream_scheduler
//   Decides per retired instruction whether to capture it (cfg_mode plus the
//   filter's drop verdict), buffers captured records in a show-ahead FIFO and
//   streams them out. Records arriving while the FIFO is full are counted and
//   summarised by one marker record once space returns.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   cfg_mode         : 0=off, 1=filtered, 2=all, 3=off
//   pc_valid/pc/instr: retired instruction
//   drop_instr       : filter verdict for the current instruction
//   m                : output record stream (master side)
//   halt_cpu         : registered almost-full request to the CPU
//   fifo_level       : current FIFO occupancy (records + markers)
//   lost_total       : saturating count of lost records since reset
module trace_stream_scheduler #(
   parameter int unsigned FIFO_DEPTH         = 16,
   parameter int unsigned PC_WIDTH           = 64,
   parameter int unsigned INSTR_WIDTH        = 32,
   parameter int unsigned ALMOST_FULL_MARGIN = 4,
   parameter int unsigned LOST_CNT_WIDTH     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    cfg_mode,
   input  logic                          pc_valid,
   input  logic [PC_WIDTH-1:0]           pc,
   input  logic [INSTR_WIDTH-1:0]        instr,
   input  logic                          drop_instr,
   trace_stream_scheduler_if.master      m,
   output logic                          halt_cpu,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [LOST_CNT_WIDTH-1:0]     lost_total
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned DW = PC_WIDTH + INSTR_WIDTH;
   localparam logic [LW-1:0] HALT_LEVEL = LW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

   typedef enum logic {NORMAL, LOST} state_t;

   function automatic logic [LOST_CNT_WIDTH-1:0] sat_inc(input logic [LOST_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [DW-1:0]             mem_data_q   [FIFO_DEPTH];
   logic                      mem_marker_q [FIFO_DEPTH];

   logic [LW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]             rd_ptr_q, rd_ptr_d;
   state_t                    state_q, state_d;
   logic [LOST_CNT_WIDTH-1:0] lost_cnt_q, lost_cnt_d;
   logic [LOST_CNT_WIDTH-1:0] lost_total_q, lost_total_d;
   logic                      halt_q, halt_d;

   logic                      capture;
   logic                      full, empty;
   logic                      push, pop;
   logic [DW-1:0]             wr_data;
   logic                      wr_marker;
   logic [LW-1:0]             level, level_next;

   // Pointers carry one extra wrap bit: equal -> empty, equal except the
   // wrap bit -> full.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;

   assign capture = pc_valid && ((cfg_mode == 2'd2) || ((cfg_mode == 2'd1) && !drop_instr));
   assign pop     = !empty && m.m_ready;

   always_comb begin
      push         = 1'b0;
      wr_data      = {pc, instr};
      wr_marker    = 1'b0;
      state_d      = state_q;
      lost_cnt_d   = lost_cnt_q;
      lost_total_d = lost_total_q;

      unique case (state_q)
         NORMAL: begin
            if (capture) begin
               if (!full) begin
                  push = 1'b1;
               end else begin
                  lost_cnt_d   = {{(LOST_CNT_WIDTH-1){1'b0}}, 1'b1};
                  lost_total_d = sat_inc(lost_total_q);
                  state_d      = LOST;
               end
            end
         end
         LOST: begin
            if (full) begin
               if (capture) begin
                  lost_cnt_d   = sat_inc(lost_cnt_q);
                  lost_total_d = sat_inc(lost_total_q);
               end
            end else begin
               // First free slot goes to the marker; a capture in this same
               // cycle is folded into the marker count instead of written.
               push      = 1'b1;
               wr_marker = 1'b1;
               wr_data   = DW'(capture ? sat_inc(lost_cnt_q) : lost_cnt_q);
               if (capture) begin
                  lost_total_d = sat_inc(lost_total_q);
               end
               lost_cnt_d = '0;
               state_d    = NORMAL;
            end
         end
         default: state_d = NORMAL;
      endcase

      wr_ptr_d   = wr_ptr_q + LW'(push);
      rd_ptr_d   = rd_ptr_q + LW'(pop);
      level_next = level + LW'(push) - LW'(pop);
      halt_d     = (level_next >= HALT_LEVEL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         state_q      <= NORMAL;
         lost_cnt_q   <= '0;
         lost_total_q <= '0;
         halt_q       <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         state_q      <= state_d;
         lost_cnt_q   <= lost_cnt_d;
         lost_total_q <= lost_total_d;
         halt_q       <= halt_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q[AW-1:0]]   <= wr_data;
         mem_marker_q[wr_ptr_q[AW-1:0]] <= wr_marker;
      end
   end

   assign m.m_valid     = !empty;
   assign m.m_data      = mem_data_q[rd_ptr_q[AW-1:0]];
   assign m.m_is_marker = !empty && mem_marker_q[rd_ptr_q[AW-1:0]];

   assign halt_cpu   = halt_q;
   assign fifo_level = level;
   assign lost_total = lost_total_q;

endmodule
